// File: rtl/muldiv_pkg.sv
// RV32M multiply/divide shared types and helpers.
// Op codes, sequencer states and operand-sign decode.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    localparam logic [6:0] M_FUNCT7  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_m_op(input logic [6:0] f7);
        return f7 == M_FUNCT7;
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or
// shift/subtract/restore divide on the {hi, lo} pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   hi_n,
    output logic [WIDTH-1:0] lo_n
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shl;
    logic [WIDTH+2:0] diff;
    logic             borrow;

    // mul: add multiplicand on LSB then shift right; div: trial subtract
    always_comb begin
        sum    = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, opnd} : '0);
        shl    = {hi, lo[WIDTH-1]};
        diff   = {1'b0, shl} - {3'b000, opnd};
        borrow = diff[WIDTH+2];
        if (div) begin
            hi_n = borrow ? shl[WIDTH:0] : diff[WIDTH:0];
            lo_n = {lo[WIDTH-2:0], ~borrow};
        end else begin
            hi_n = {1'b0, sum[WIDTH:1]};
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer.
// Holds the pipeline via Stall while an op is in flight.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Stall
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [2:0]         f3_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd_q, lo_q, fast_q, result_q;
    logic [WIDTH:0]     hi_q, hi_n;
    logic [WIDTH-1:0]   lo_n;
    logic [CW-1:0]      cnt_q;
    logic               negq_q, negr_q, fast_en_q, done_q;

    logic               div_op, sa, sb, dz, ovf;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, remv, fix_res;
    logic [2*WIDTH-1:0] prod, prod_n;

    assign div_op = is_div(f3_q);
    assign Busy   = (state != IDLE);
    assign Done   = done_q;
    assign Result = result_q;
    assign Stall  = Busy | (Start & (state == IDLE));

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div  (div_op),
        .hi   (hi_q),
        .lo   (lo_q),
        .opnd (opnd_q),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    // operand sign decode, magnitudes and the two bypass cases
    always_comb begin
        sa    = is_signed_a(f3_q) & a_q[WIDTH-1];
        sb    = is_signed_b(f3_q) & b_q[WIDTH-1];
        abs_a = sa ? ('0 - a_q) : a_q;
        abs_b = sb ? ('0 - b_q) : b_q;
        dz    = div_op && (b_q == '0);
        ovf   = div_op && is_signed_a(f3_q) &&
                (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    end

    // sign fix-up and output select
    always_comb begin
        prod   = {hi_q[WIDTH-1:0], lo_q};
        prod_n = negq_q ? ('0 - prod) : prod;
        quo    = negq_q ? ('0 - lo_q) : lo_q;
        remv   = negr_q ? ('0 - hi_q[WIDTH-1:0]) : hi_q[WIDTH-1:0];
        if (fast_en_q)
            fix_res = fast_q;
        else if (is_rem(f3_q))
            fix_res = remv;
        else if (div_op)
            fix_res = quo;
        else if (f3_q == F3_MUL)
            fix_res = prod_n[WIDTH-1:0];
        else
            fix_res = prod_n[2*WIDTH-1:WIDTH];
    end

    // sequencer FSM and datapath registers; Flush wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            fast_en_q <= 1'b0;
            fast_q    <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (Flush && state != IDLE) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (Start && !Flush) begin
                            f3_q  <= Funct3;
                            a_q   <= SrcA;
                            b_q   <= SrcB;
                            state <= PREP;
                        end
                    end
                    PREP: begin
                        negq_q    <= sa ^ sb;
                        negr_q    <= sa;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                        opnd_q    <= div_op ? abs_b : abs_a;
                        lo_q      <= div_op ? abs_a : abs_b;
                        fast_en_q <= dz | ovf;
                        if (dz)
                            fast_q <= is_rem(f3_q) ? a_q : '1;
                        else
                            fast_q <= is_rem(f3_q) ? '0 : a_q;
                        state     <= (dz | ovf) ? FIX : RUN;
                    end
                    RUN: begin
                        hi_q  <= hi_n;
                        lo_q  <= lo_n;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1))
                            state <= FIX;
                    end
                    FIX: begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Directed RV32M cases plus random ops against a 64-bit arithmetic model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        Busy, Done, Stall;
    logic [31:0] Result;

    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Flush  (Flush),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .Stall  (Stall)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = 0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (f3[2] && b == 0) return 3;
        if ((f3 == 3'd4 || f3 == 3'd6) &&
            a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        return 35;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after a rising edge with the DUT idle; Start is in cycle 0.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat, input bit poke);
        int cyc;
        Start  = 1'b1;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
        #1;
        check("stall_c0", {31'b0, Stall}, 32'd1);
        @(posedge clk); #1;
        Start  = 1'b0;
        Funct3 = 3'($urandom);
        SrcA   = $urandom;
        SrcB   = $urandom;
        cyc    = 1;
        check("busy_c1", {31'b0, Busy}, 32'd1);
        while (!Done && cyc < 60) begin
            Start = (poke && cyc == 5);
            @(posedge clk); #1;
            cyc++;
        end
        Start = 1'b0;
        check("done_cycle", cyc, lat);
        check("result", Result, exp);
        last_exp = exp;
        @(posedge clk); #1;
        check("busy_after", {31'b0, Busy}, 32'd0);
        check("done_pulse", {31'b0, Done}, 32'd0);
        check("result_held", Result, exp);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;

        #12;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_stall", {31'b0, Stall}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0);
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 3, 1'b0);
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 3, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 35, 1'b1);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 35, 1'b0);

        // Flush at cycle 10 of a DIV, then a new Start at cycle 12
        Start  = 1'b1;
        Funct3 = 3'd4;
        SrcA   = 32'd1000;
        SrcB   = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        check("flush_busy", {31'b0, Busy}, 32'd0);
        check("flush_done", {31'b0, Done}, 32'd0);
        check("flush_result", Result, last_exp);
        @(posedge clk); #1;
        check("flush_c12_done", {31'b0, Done}, 32'd0);
        run_op(3'd4, 32'd1000, 32'hFFFF_FFFD,
               model(3'd4, 32'd1000, 32'hFFFF_FFFD), 35, 1'b0);

        // Flush together with Start in IDLE drops the request
        Start  = 1'b1;
        Flush  = 1'b1;
        Funct3 = 3'd0;
        @(posedge clk); #1;
        Start = 1'b0;
        Flush = 1'b0;
        check("flush_start_busy", {31'b0, Busy}, 32'd0);
        @(posedge clk); #1;
        check("flush_start_busy2", {31'b0, Busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(f3, a, b, model(f3, a, b), model_lat(f3, a, b),
                   1'($urandom_range(0, 1)));
        end

        // async reset at cycle 20 of an op
        run_op(3'd0, 32'd3, 32'd5, 32'd15, 35, 1'b0);
        Start  = 1'b1;
        Funct3 = 3'd3;
        SrcA   = 32'h1234_5678;
        SrcB   = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, Busy}, 32'd0);
        check("arst_done", {31'b0, Done}, 32'd0);
        check("arst_result", Result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 32'd7, 32'd6, 32'd42, 35, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
